// File: rtl/hack_reg_stack.sv
// hack_reg_stack: parametrised LIFO register stack for the Hack CPU datapath.
// It serves as a return-address and operand stack beside the A/D registers.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   push      in   write data_in as the new top this cycle
//   pop       in   remove the current top this cycle
//   data_in   in   [WIDTH] value to push
//   clr_err   in   clear the sticky overflow/underflow flags
//   top_out   out  [WIDTH] current top of stack, 0 when empty (combinational)
//   count     out  [CW] number of valid entries, 0..DEPTH
//   empty     out  count == 0 (combinational decode)
//   full      out  count == DEPTH (combinational decode)
//   overflow  out  sticky: a push was rejected while full
//   underflow out  sticky: a pop was rejected while empty
//
// Optional build macro HACK_REG_STACK_PEEK_EN adds:
//   peek_idx  in   [CW] depth below the top to read (0 = top)
//   peek_out  out  [WIDTH] entry[count-1-peek_idx], 0 when peek_idx >= count
module hack_reg_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
`ifdef HACK_REG_STACK_PEEK_EN
  input  logic [CW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_out,
`endif
  output logic [WIDTH-1:0] top_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             empty_c, full_c;

  assign empty_c = (count_q == CW'(0));
  assign full_c  = (count_q == CW'(DEPTH));
  // Only meaningful when not empty; the read is masked below otherwise.
  assign top_idx = AW'(count_q - CW'(1));

  // Operation decode: next count, sticky flags and storage write port.
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    wr_en       = 1'b0;
    wr_idx      = '0;
    unique case ({push, pop})
      2'b10: begin
        if (full_c) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count_q);
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty_c) begin
          underflow_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      2'b11: begin
        // Replace-top; on an empty stack it degenerates to a plain push.
        wr_en = 1'b1;
        if (empty_c) begin
          wr_idx  = '0;
          count_d = CW'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
    if (reset) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      wr_en       = 1'b0;
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    count_q     <= count_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // Storage is never cleared; stale entries stay hidden behind count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_in;
    end
  end

  assign top_out   = empty_c ? '0 : mem_q[top_idx];
  assign count     = count_q;
  assign empty     = empty_c;
  assign full      = full_c;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef HACK_REG_STACK_PEEK_EN
  logic [AW-1:0] peek_addr;

  assign peek_addr = AW'(count_q - CW'(1) - peek_idx);
  assign peek_out  = (peek_idx >= count_q) ? '0 : mem_q[peek_addr];
`endif

endmodule

// File: tb/tb_hack_reg_stack.sv
// Directed bench for hack_reg_stack (DEPTH = 16, WIDTH = 16).
module tb_hack_reg_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, push, pop, clr_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] top_out;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;
`ifdef HACK_REG_STACK_PEEK_EN
  logic [CW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  hack_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .clr_err   (clr_err),
`ifdef HACK_REG_STACK_PEEK_EN
    .peek_idx  (peek_idx),
    .peek_out  (peek_out),
`endif
    .top_out   (top_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ps, input logic pp, input logic [WIDTH-1:0] d,
                      input logic ce, input logic rs);
    push = ps; pop = pp; data_in = d; clr_err = ce; reset = rs;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = '0; clr_err = 1'b0; reset = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] c, input logic [31:0] t,
                           input logic e, input logic f, input logic o, input logic u);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".top"}, 32'(top_out), t);
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".ovf"}, 32'(overflow), 32'(o));
    chk({tag, ".unf"}, 32'(underflow), 32'(u));
  endtask

  initial begin
    push = 1'b0; pop = 1'b0; data_in = '0; clr_err = 1'b0; reset = 1'b1;
`ifdef HACK_REG_STACK_PEEK_EN
    peek_idx = '0;
`endif
    step(0, 0, 16'h0, 0, 1);
    chk_state("reset", 0, 0, 1, 0, 0, 0);

    // Basic push / pop ordering.
    step(1, 0, 16'h1111, 0, 0);
    chk_state("push1", 1, 32'h1111, 0, 0, 0, 0);
    step(1, 0, 16'h2222, 0, 0);
    step(1, 0, 16'h3333, 0, 0);
    chk_state("push3", 3, 32'h3333, 0, 0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("pop1", 2, 32'h2222, 0, 0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("pop2", 1, 32'h1111, 0, 0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("pop3", 0, 0, 1, 0, 0, 0);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 16; i++) step(1, 0, 16'(i), 0, 0);
    chk_state("fill", 16, 32'h000F, 0, 1, 0, 0);
    step(1, 0, 16'hBEEF, 0, 0);
    chk_state("ovf", 16, 32'h000F, 0, 1, 1, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("ovf_pop", 15, 32'h000E, 0, 0, 1, 0);
    step(0, 0, 16'h0, 1, 0);
    chk_state("ovf_clr", 15, 32'h000E, 0, 0, 0, 0);

    // Underflow, and set-wins over clr_err.
    step(0, 0, 16'h0, 0, 1);
    chk_state("rst2", 0, 0, 1, 0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("unf", 0, 0, 1, 0, 0, 1);
    step(0, 1, 16'h0, 1, 0);
    chk_state("unf_setwins", 0, 0, 1, 0, 0, 1);
    step(0, 0, 16'h0, 1, 0);
    chk_state("unf_clr", 0, 0, 1, 0, 0, 0);

    // Replace-top.
    step(1, 0, 16'h1234, 0, 0);
    step(1, 0, 16'hAAAA, 0, 0);
    chk_state("pre_rep", 2, 32'hAAAA, 0, 0, 0, 0);
    step(1, 1, 16'h5555, 0, 0);
    chk_state("rep", 2, 32'h5555, 0, 0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("rep_pop", 1, 32'h1234, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 16'(16'h0100 + i), 0, 0);
    chk_state("refill", 16, 32'h010E, 0, 1, 0, 0);
    step(1, 1, 16'hCAFE, 0, 0);
    chk_state("rep_full", 16, 32'hCAFE, 0, 1, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk_state("rep_full_pop", 15, 32'h010D, 0, 0, 0, 0);

    // Push+pop on empty acts as push.
    step(0, 0, 16'h0, 0, 1);
    step(1, 1, 16'h0042, 0, 0);
    chk_state("pp_empty", 1, 32'h0042, 0, 0, 0, 0);

    // Reset with pending push while overflow is set and 5 entries remain.
    step(0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 16'(16'h0200 + i), 0, 0);
    step(1, 0, 16'hDEAD, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 16'h0, 0, 0);
    chk_state("five_ovf", 5, 32'h0204, 0, 0, 1, 0);
    step(1, 0, 16'h9999, 0, 1);
    chk_state("rst_push", 0, 0, 1, 0, 0, 0);
    step(1, 0, 16'h7777, 0, 0);
    chk_state("post_rst", 1, 32'h7777, 0, 0, 0, 0);

`ifdef HACK_REG_STACK_PEEK_EN
    step(0, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0010, 0, 0);
    step(1, 0, 16'h0020, 0, 0);
    step(1, 0, 16'h0030, 0, 0);
    peek_idx = CW'(0); #1; chk("peek0", 32'(peek_out), 32'h30);
    peek_idx = CW'(1); #1; chk("peek1", 32'(peek_out), 32'h20);
    peek_idx = CW'(2); #1; chk("peek2", 32'(peek_out), 32'h10);
    peek_idx = CW'(3); #1; chk("peek3", 32'(peek_out), 32'h0);
    step(0, 0, 16'h0, 0, 0);
    chk_state("peek_nosfx", 3, 32'h0030, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
